// File: rtl/pc_stack_engine.sv
// Call/return sequencer: spills a 16-bit PC as two bytes onto a downward-growing
// memory stack and reads it back. Optional overflow/underflow guard: STACK_GUARD_EN.
module pc_stack_engine #(
    parameter logic [15:0] STACK_BASE  = 16'hFFFF,
    parameter int          STACK_DEPTH = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        push_req,
    input  logic        pop_req,
    input  logic [15:0] pc_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] pc_out,
    output logic [15:0] sp,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_HI = 3'd1,
        PUSH_LO = 3'd2,
        POP_LO  = 3'd3,
        POP_HI  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        push_blk, pop_blk;

`ifdef STACK_GUARD_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;

    assign push_blk = (depth_q == DW'(STACK_DEPTH));
    assign pop_blk  = (depth_q == '0);
    // err_q is only ever set on the way into DONE, so it is already a one-cycle pulse
    assign error    = err_q;
`else
    assign push_blk = 1'b0;
    assign pop_blk  = 1'b0;
    assign error    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        pc_d      = pc_q;
        lo_d      = lo_q;
        pc_out_d  = pc_out_q;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
`ifdef STACK_GUARD_EN
        depth_d   = depth_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (push_req) begin
                    if (push_blk) begin
                        state_d = DONE;
`ifdef STACK_GUARD_EN
                        err_d   = 1'b1;
`endif
                    end else begin
                        pc_d    = pc_in;
                        state_d = PUSH_HI;
                    end
                end else if (pop_req) begin
                    if (pop_blk) begin
                        state_d = DONE;
`ifdef STACK_GUARD_EN
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = POP_LO;
                    end
                end
            end
            PUSH_HI: begin
                mem_wr    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = pc_q[15:8];
                if (mem_ack) state_d = PUSH_LO;
            end
            PUSH_LO: begin
                mem_wr    = 1'b1;
                mem_addr  = sp_q - 16'd1;
                mem_wdata = pc_q[7:0];
                if (mem_ack) begin
                    sp_d    = sp_q - 16'd2;
                    state_d = DONE;
`ifdef STACK_GUARD_EN
                    depth_d = depth_q + 1'b1;
`endif
                end
            end
            POP_LO: begin
                mem_rd   = 1'b1;
                mem_addr = sp_q + 16'd1;
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    state_d = POP_HI;
                end
            end
            POP_HI: begin
                mem_rd   = 1'b1;
                mem_addr = sp_q + 16'd2;
                if (mem_ack) begin
                    pc_out_d = {mem_rdata, lo_q};
                    sp_d     = sp_q + 16'd2;
                    state_d  = DONE;
`ifdef STACK_GUARD_EN
                    depth_d  = depth_q - 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sp_q     <= STACK_BASE;
            pc_q     <= 16'h0000;
            lo_q     <= 8'h00;
            pc_out_q <= 16'h0000;
`ifdef STACK_GUARD_EN
            depth_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            pc_q     <= pc_d;
            lo_q     <= lo_d;
            pc_out_q <= pc_out_d;
`ifdef STACK_GUARD_EN
            depth_q  <= depth_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign pc_out = pc_out_q;
    assign sp     = sp_q;

endmodule

// File: tb/tb_pc_stack_engine.sv
// Directed bench for pc_stack_engine with a byte memory responder of programmable ack delay.
module tb_pc_stack_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        push_req, pop_req;
    logic [15:0] pc_in;
    logic        busy, done, error;
    logic [15:0] pc_out, sp, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd, mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:65535];
    int ack_dly = 0;
    int wcnt    = 0;
    int wr_acc  = 0;
    int rd_acc  = 0;

    pc_stack_engine #(.STACK_BASE(16'hFFFF), .STACK_DEPTH(2)) dut (
        .clock(clock), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
        .pc_in(pc_in), .busy(busy), .done(done), .pc_out(pc_out), .sp(sp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .error(error)
    );

    always #5 clock = ~clock;

    // Memory responder: acks after ack_dly stall cycles; writes commit on the acked cycle.
    always @(negedge clock) begin
        if (mem_wr || mem_rd) begin
            if (wcnt == ack_dly) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_wr) begin
                    mem[mem_addr] = mem_wdata;
                    wr_acc++;
                end else begin
                    mem_rdata = mem[mem_addr];
                    rd_acc++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h5A;
        mem[16'h0001] = 8'hC3;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        reset_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; pc_in = 16'h0000;
        cyc(); cyc();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sp", sp, 16'hFFFF);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_strobes", {mem_wr, mem_rd, error}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clock); reset_n = 1'b1;
        cyc();

`ifndef STACK_GUARD_EN
        // 1: push 1234, ack tied high -> done in N+3
        push_req = 1'b1; pc_in = 16'h1234;
        cyc();                                  // edge N
        push_req = 1'b0; pc_in = 16'h0000;
        chk("t1_hi", {busy, mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h12});
        chk("t1_hi_done", done, 0);
        cyc();
        chk("t1_lo", {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 16'hFFFE, 8'h34});
        cyc();
        chk("t1_done", {done, busy, mem_wr}, 3'b110);
        chk("t1_sp", sp, 16'hFFFD);
        chk("t1_mem", {mem[16'hFFFF], mem[16'hFFFE]}, 16'h1234);
        cyc();
        chk("t1_idle", {done, busy}, 2'b00);

        // 2: pop -> reads FFFE then FFFF
        pop_req = 1'b1;
        cyc();
        pop_req = 1'b0;
        chk("t2_lo", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 16'hFFFE});
        cyc();
        chk("t2_hi", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 16'hFFFF});
        cyc();
        chk("t2_done", done, 1);
        chk("t2_pc_out", pc_out, 16'h1234);
        chk("t2_sp", sp, 16'hFFFF);
        cyc();

        // 3: 3-cycle ack stall per access -> done at N+9
        ack_dly = 3;
        push_req = 1'b1; pc_in = 16'hABCD;
        cyc();
        push_req = 1'b0; pc_in = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hi_hold", {done, mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b0, 1'b1, 1'b0, 16'hFFFF, 8'hAB});
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_lo_hold", {done, mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b0, 1'b1, 1'b0, 16'hFFFE, 8'hCD});
            cyc();
        end
        chk("t3_done", {done, mem_wr}, 2'b10);
        chk("t3_sp", sp, 16'hFFFD);
        chk("t3_mem", {mem[16'hFFFF], mem[16'hFFFE]}, 16'hABCD);
        cyc();
        ack_dly = 0;

        // 4: push wins over simultaneous pop; pop held during busy is dropped
        push_req = 1'b1; pop_req = 1'b1; pc_in = 16'h5678;
        cyc();
        push_req = 1'b0;
        chk("t4_hi", {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 16'hFFFD, 8'h56});
        cyc();
        chk("t4_lo", {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 16'hFFFC, 8'h78});
        cyc();
        pop_req = 1'b0;
        chk("t4_done", {done, sp}, {1'b1, 16'hFFFB});
        cyc();
        chk("t4_no_pop", {busy, mem_rd, sp}, {1'b0, 1'b0, 16'hFFFB});

        // 5: reset during PUSH_LO aborts at once
        push_req = 1'b1; pc_in = 16'h9999;
        cyc();
        push_req = 1'b0;
        cyc();
        chk("t5_in_lo", {mem_wr, mem_addr}, {1'b1, 16'hFFFA});
        reset_n = 1'b0;
        #1;
        chk("t5_abort", {busy, done, mem_wr, mem_rd, mem_addr}, {4'b0000, 16'h0000});
        chk("t5_sp", sp, 16'hFFFF);
        @(negedge clock); reset_n = 1'b1;
        cyc();

        // unguarded pop on empty stack wraps to 0000/0001
        pop_req = 1'b1;
        cyc();
        pop_req = 1'b0;
        chk("wrap_lo_addr", mem_addr, 16'h0000);
        cyc();
        chk("wrap_hi_addr", mem_addr, 16'h0001);
        cyc();
        chk("wrap_pc_out", {done, error, pc_out}, {2'b10, 16'hC35A});
        chk("wrap_sp", sp, 16'h0001);
        cyc();
`else
        // 6: guard with STACK_DEPTH=2; underflow first
        pop_req = 1'b1;
        cyc();
        pop_req = 1'b0;
        chk("g_uf", {done, error, mem_rd, mem_wr}, 4'b1100);
        chk("g_uf_state", {sp, pc_out}, {16'hFFFF, 16'h0000});
        chk("g_uf_rd", rd_acc, 0);
        cyc();
        chk("g_uf_end", {done, error, busy}, 3'b000);

        push_req = 1'b1; pc_in = 16'h1111;
        cyc(); push_req = 1'b0; cyc(); cyc();
        chk("g_p1", {done, error, sp}, {2'b10, 16'hFFFD});
        cyc();
        push_req = 1'b1; pc_in = 16'h2222;
        cyc(); push_req = 1'b0; cyc(); cyc();
        chk("g_p2", {done, error, sp}, {2'b10, 16'hFFFB});
        cyc();
        chk("g_wr_before", wr_acc, 4);
        push_req = 1'b1; pc_in = 16'h3333;
        cyc();
        push_req = 1'b0;
        chk("g_of", {done, error, mem_wr, mem_rd}, 4'b1100);
        chk("g_of_sp", sp, 16'hFFFB);
        cyc();
        chk("g_of_wr", wr_acc, 4);

        pop_req = 1'b1;
        cyc(); pop_req = 1'b0; cyc(); cyc();
        chk("g_pop", {done, error, pc_out, sp}, {2'b10, 16'h2222, 16'hFFFD});
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
